// File: rtl/game_status.sv
// Space Invaders game-level FSM: kills, lives, pause and WIN/LOSE banner hold.
// Define GAME_STATUS_BTN_SYNC_EN to add a 2-flop synchronizer on start_btn.
module game_status #(
  parameter int NUM_ALIENS   = 55,
  parameter int LIVES        = 3,
  parameter int PAUSE_FRAMES = 60,
  parameter int HOLD_FRAMES  = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       alien_hit,
  input  logic       player_hit,
  input  logic       invaded,
  output logic       playing,
  output logic       paused,
  output logic       winner,
  output logic       loser,
  output logic [6:0] kills,
  output logic [2:0] lives
);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    PLAY  = 5'b00010,
    PAUSE = 5'b00100,
    WIN   = 5'b01000,
    LOSE  = 5'b10000
  } state_t;

  localparam logic [6:0] K_MAX  = 7'(NUM_ALIENS);
  localparam logic [6:0] K_LAST = 7'(NUM_ALIENS - 1);
  localparam logic [2:0] L_INIT = 3'(LIVES);
  localparam logic [9:0] P_LOAD = 10'(PAUSE_FRAMES);
  localparam logic [9:0] H_LOAD = 10'(HOLD_FRAMES);

  state_t     state, state_nx;
  logic [6:0] kills_q, kills_nx;
  logic [2:0] lives_q, lives_nx;
  logic [9:0] cnt, cnt_nx;
  logic       btn;
  logic       btn_d;
  logic       start_pulse;

`ifdef GAME_STATUS_BTN_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '0;
    else      sync <= {sync[0], start_btn};
  end

  assign btn = sync[1];
`else
  assign btn = start_btn;
`endif

  // Registered pulse keeps the start path off the state logic's input cone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_d       <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      btn_d       <= btn;
      start_pulse <= btn & ~btn_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      kills_q <= '0;
      lives_q <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      kills_q <= kills_nx;
      lives_q <= lives_nx;
      cnt     <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    kills_nx = kills_q;
    lives_nx = lives_q;
    cnt_nx   = cnt;
    unique case (1'b1)
      state[0]: begin
        if (start_pulse) begin
          state_nx = PLAY;
          kills_nx = '0;
          lives_nx = L_INIT;
        end
      end
      state[1]: begin
        if (alien_hit && kills_q == K_LAST) begin
          state_nx = WIN;
          kills_nx = K_MAX;
          cnt_nx   = H_LOAD;
        end else begin
          if (alien_hit && !invaded && kills_q < K_MAX)
            kills_nx = kills_q + 7'd1;
          if (invaded) begin
            state_nx = LOSE;
            lives_nx = '0;
            cnt_nx   = H_LOAD;
          end else if (player_hit && lives_q <= 3'd1) begin
            state_nx = LOSE;
            lives_nx = '0;
            cnt_nx   = H_LOAD;
          end else if (player_hit) begin
            state_nx = PAUSE;
            lives_nx = lives_q - 3'd1;
            cnt_nx   = P_LOAD;
          end
        end
      end
      state[2]: begin
        if (frame_tick) begin
          if (cnt <= 10'd1) begin
            state_nx = PLAY;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - 10'd1;
          end
        end
      end
      state[3], state[4]: begin
        if (frame_tick && cnt != '0)
          cnt_nx = cnt - 10'd1;
        if (start_pulse && cnt == '0)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One-hot state bits feed the flags directly, so they cannot glitch.
  always_comb begin
    playing = state[1];
    paused  = state[2];
    winner  = state[3];
    loser   = state[4];
    kills   = kills_q;
    lives   = lives_q;
  end

endmodule
